// File: rtl/mem_burst_ctrl_if.sv
// Bundle of signals between the burst controller, its command/write-data source,
// its read-data consumer and the attached synchronous memory.
//   slave  : controller view (takes commands and drives the memory port)
//   master : environment view (issues commands, supplies write data, models memory)
// Signals:
//   CMD_VALID/CMD_READY/CMD_WE/CMD_ADDR/CMD_LEN : burst command handshake
//   WD_VALID/WD_DATA/WD_READY                   : write-data beats
//   RD_VALID/RD_DATA                            : read-data beats (no backpressure)
//   MEM_ADDR/MEM_DATA/MEM_WREN/MEM_Q            : memory port
//   BUSY                                        : burst or read beat outstanding
interface mem_burst_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned LEN_WIDTH  = 4
);
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic                  CMD_WE;
    logic [ADDR_WIDTH-1:0] CMD_ADDR;
    logic [LEN_WIDTH-1:0]  CMD_LEN;
    logic                  WD_VALID;
    logic [DATA_WIDTH-1:0] WD_DATA;
    logic                  WD_READY;
    logic                  RD_VALID;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [DATA_WIDTH-1:0] MEM_DATA;
    logic                  MEM_WREN;
    logic [DATA_WIDTH-1:0] MEM_Q;
    logic                  BUSY;

    modport slave (
        input  CMD_VALID, CMD_WE, CMD_ADDR, CMD_LEN, WD_VALID, WD_DATA, MEM_Q,
        output CMD_READY, WD_READY, RD_VALID, RD_DATA, MEM_ADDR, MEM_DATA, MEM_WREN, BUSY
    );

    modport master (
        output CMD_VALID, CMD_WE, CMD_ADDR, CMD_LEN, WD_VALID, WD_DATA, MEM_Q,
        input  CMD_READY, WD_READY, RD_VALID, RD_DATA, MEM_ADDR, MEM_DATA, MEM_WREN, BUSY
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst command controller, sole master of a synchronous (1-cycle read latency,
// write-through) memory. Accepts read/write bursts, walks the memory with an
// auto-incrementing address, and returns read data one cycle after each issue.
// Ports:
//   CLK   : clock, all state changes on posedge
//   RESET : asynchronous active-high reset; aborts any burst immediately
//   bus   : mem_burst_ctrl_if.slave (command, write data, read data, memory port, BUSY)
module mem_burst_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    mem_burst_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
    logic                  rd_pend_q;

    logic                  cmd_ready;
    logic                  wd_ready;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] wd_data;
    logic [DATA_WIDTH-1:0] rd_data;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            rd_pend_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            // A beat issued this cycle returns from memory next cycle.
            rd_pend_q    <= (state_q == StRead);
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        cmd_ready    = 1'b0;
        wd_ready     = 1'b0;
        mem_wren     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (bus.CMD_VALID) begin
                    cur_addr_d   = bus.CMD_ADDR;
                    beats_left_d = bus.CMD_LEN;
                    state_d      = bus.CMD_WE ? StWrite : StRead;
                end
            end
            StWrite: begin
                wd_ready = 1'b1;
                mem_wren = bus.WD_VALID;
                // WD_VALID low is a stall: address and count hold.
                if (bus.WD_VALID) begin
                    cur_addr_d = cur_addr_q + 1'b1;
                    if (beats_left_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        beats_left_d = beats_left_q - 1'b1;
                    end
                end
            end
            StRead: begin
                cur_addr_d = cur_addr_q + 1'b1;
                if (beats_left_q == '0) begin
                    state_d = StIdle;
                end else begin
                    beats_left_d = beats_left_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign wd_data = bus.WD_DATA;
    assign rd_data = bus.MEM_Q;

    // State already sits at StIdle during reset, so the handshake outputs are
    // gated to keep the environment quiet until reset is released.
    assign bus.CMD_READY = cmd_ready & ~RESET;
    assign bus.WD_READY  = wd_ready & ~RESET;
    assign bus.MEM_WREN  = mem_wren & ~RESET;
    assign bus.MEM_ADDR  = cur_addr_q;
    assign bus.MEM_DATA  = wd_data;
    assign bus.RD_VALID  = rd_pend_q;
    assign bus.RD_DATA   = rd_data;
    assign bus.BUSY      = (state_q != StIdle) | rd_pend_q;

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst command controller that sits directly upstream of the DFF `memory` block and is its only master. It accepts read/write burst commands over a valid/ready handshake, drives the memory's ADDR/DATA/WREN with auto-incrementing addresses, and returns read data aligned to the memory's one-cycle synchronous read latency. It sequences bursts with a three-state FSM and supports per-beat write-data stalls.

## Interface
- ADDR_WIDTH, 4, memory address width; must match the attached memory
- DATA_WIDTH, 4, data width; must match the attached memory
- LEN_WIDTH, 4, burst length field width; max burst is 2^LEN_WIDTH beats

Ports:
- CLK  in  1  clock; all state changes on posedge
- RESET  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  controller can accept a command
- CMD_WE  in  1  1 = write burst, 0 = read burst
- CMD_ADDR  in  ADDR_WIDTH  burst start address
- CMD_LEN  in  LEN_WIDTH  beats minus one
- WD_VALID  in  1  write-data beat offered
- WD_DATA  in  DATA_WIDTH  write-data beat
- WD_READY  out  1  write beat accepted this cycle
- RD_VALID  out  1  RD_DATA holds a read beat this cycle
- RD_DATA  out  DATA_WIDTH  read beat
- MEM_ADDR  out  ADDR_WIDTH  to memory ADDR
- MEM_DATA  out  DATA_WIDTH  to memory DATA
- MEM_WREN  out  1  to memory WREN
- MEM_Q  in  DATA_WIDTH  from memory Q
- BUSY  out  1  burst in progress or read beat outstanding

## Operation
- Registers:
  - state ∈ {IDLE, WRITE, READ}
  - cur_addr (ADDR_WIDTH)
  - beats_left (LEN_WIDTH)
  - rd_pend (1)
- IDLE:
  - CMD_READY = 1 when RESET is low.
  - On CMD_VALID && CMD_READY: cur_addr <= CMD_ADDR, beats_left <= CMD_LEN, state <= CMD_WE ? WRITE : READ.
  - No command in flight means no transition.
- WRITE:
  - WD_READY = 1.
  - MEM_WREN = WD_VALID.
  - MEM_DATA = WD_DATA.
  - MEM_ADDR = cur_addr.
  - On each WD_VALID cycle: cur_addr <= cur_addr + 1 (mod 2^ADDR_WIDTH). If beats_left == 0, state <= IDLE; else beats_left <= beats_left - 1.
  - WD_VALID low is a stall: MEM_WREN = 0 and counters hold.
- READ:
  - MEM_WREN = 0.
  - MEM_ADDR = cur_addr.
  - One beat is issued every cycle with no stalls: cur_addr increments and beats_left decrements.
  - After the beat with beats_left == 0, state <= IDLE.
- rd_pend <= (state == READ) each cycle.
- RD_VALID = rd_pend.
- RD_DATA = MEM_Q, combinational passthrough.
- There is no read backpressure. The consumer must take every RD_VALID beat.
- Outside WRITE: WD_READY = 0 and MEM_WREN = 0.
- MEM_DATA = WD_DATA in all states; it is ignored when MEM_WREN = 0.
- BUSY = (state != IDLE) || rd_pend.
- Address wrap: a burst crossing 2^ADDR_WIDTH-1 continues at 0. This is not an error.
- Reset:
  - state = IDLE, cur_addr = 0, beats_left = 0, rd_pend = 0.
  - Output values while RESET is high: CMD_READY = 0, WD_READY = 0, MEM_WREN = 0, MEM_ADDR = 0, RD_VALID = 0, BUSY = 0.
  - Reset mid-burst aborts the burst immediately. No further MEM_WREN is issued, and any outstanding read beat is dropped.

## Timing
- Command accept to first memory access: 1 cycle. The accept happens at edge N, and the first beat is driven in cycle N+1.
- Write beat latency:
  - A beat handshaked in cycle k is written at the edge ending cycle k.
  - Memory Q shows the written value (write-through) in cycle k+1.
- Read latency:
  - A beat issued in cycle k (MEM_ADDR = a) produces RD_VALID = 1 and RD_DATA = mem[a] in cycle k+1.
  - An L-beat read occupies cycles N+1..N+L, with RD_VALID in cycles N+2..N+L+1.
- Back-to-back commands:
  - A new command can be accepted in the IDLE cycle that carries the final RD_VALID.
  - Its first beat follows one cycle later, so there is no MEM port conflict.
- Throughput: 1 beat/cycle for reads, and for writes when WD_VALID is held high.
- A command is held off (CMD_READY = 0) for the whole burst.

## Test plan
- Reset: assert RESET mid-cycle (async) → CMD_READY, MEM_WREN, RD_VALID, BUSY all 0 immediately. After release, CMD_READY = 1 and MEM_ADDR = 0.
- Burst write then read: write ADDR 0, LEN 3, data 9,7,6,5; then read ADDR 0, LEN 3 → RD_VALID for 4 consecutive cycles with RD_DATA 9,7,6,5. Addresses 4..15 read back 0.
- Wrap-around: write ADDR 14, LEN 3, data 1,2,3,4 → MEM_ADDR sequence 14,15,0,1. Reading ADDR 14, LEN 3 returns 1,2,3,4.
- Write stalls: write LEN 2 with WD_VALID pattern 1,0,0,1,1 → exactly 3 MEM_WREN pulses, cur_addr holds during stalls, and IDLE follows the 3rd beat.
- Back-to-back: read LEN 0 at ADDR 2, then a write command accepted in the RD_VALID cycle → RD_DATA equals the old mem[2], and the write lands one cycle later with correct data.
- Reset mid-burst: write LEN 7 and assert RESET after beat 3 → only 3 MEM_WREN pulses occur, state returns to IDLE, and BUSY = 0.
